// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

    // Word-address width of the data memory.
    localparam int DATAMEM_BITS = 16;

    // Arbiter state: which requester held the port last cycle.
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CORE     = 2'd1,
        S_PER      = 2'd2,
        S_PER_LOCK = 2'd3
    } arb_state_e;

    // Owner of an access, used to route the read return.
    typedef enum logic {
        ARB_OWN_CORE = 1'b0,
        ARB_OWN_PER  = 1'b1
    } arb_owner_e;

    // Return tag captured in the grant cycle, consumed one cycle later.
    typedef struct packed {
        arb_owner_e owner;
        logic       is_read;
    } ret_tag_t;

    // Bits needed to hold a count from 0 up to and including max_val.
    function automatic int ctr_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; reports when it sits at MAX.
module arb_sat_counter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int MAX   = 8,
    parameter int WIDTH = ctr_width(MAX)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign at_max = (count_q == WIDTH'(MAX));

    // Next count: clear wins over increment, increment stops at MAX.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !at_max) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the core load/store path
// (fixed priority) and the peripheral mailbox sequencer (starvation bound,
// short locked bursts). Grants and the memory-side mux are combinational;
// read data is routed back one cycle later using a registered owner tag.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DATAMEM_BITS,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8,
    parameter int LOCK_MAX   = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [3:0]        core_be,
    output logic              core_gnt,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_rvalid,
    input  logic              per_req,
    input  logic              per_lock,
    input  logic [ADDR_W-1:0] per_addr,
    input  logic [DATA_W-1:0] per_wdata,
    input  logic [3:0]        per_be,
    output logic              per_gnt,
    output logic [DATA_W-1:0] per_rdata,
    output logic              per_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_out,
    output logic [3:0]        mem_wr,
    input  logic [DATA_W-1:0] mem_in
);

    arb_state_e state_q;
    arb_state_e state_d;
    ret_tag_t   tag_q;
    ret_tag_t   tag_d;

    logic starve_inc;
    logic starve_clr;
    logic starve_at_max;
    logic lock_inc;
    logic lock_clr;
    logic lock_at_max;
    logic lock_break;

    // Consecutive cycles the peripheral has asked and been refused.
    arb_sat_counter #(
        .MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk    (clk),
        .rst    (rst),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .at_max (starve_at_max)
    );

    // Consecutive locked peripheral grants in the current burst.
    arb_sat_counter #(
        .MAX (LOCK_MAX)
    ) u_lock_ctr (
        .clk    (clk),
        .rst    (rst),
        .inc    (lock_inc),
        .clr    (lock_clr),
        .at_max (lock_at_max)
    );

    // Grant decision: live lock, then starvation override, then core, then peripheral.
    // Nothing is granted while reset is asserted.
    always_comb begin
        core_gnt = 1'b0;
        per_gnt  = 1'b0;
        if (!rst) begin
            if ((state_q == S_PER_LOCK) && per_req && !lock_at_max) begin
                per_gnt = 1'b1;
            end else if (per_req && starve_at_max) begin
                per_gnt = 1'b1;
            end else if (core_req) begin
                core_gnt = 1'b1;
            end else if (per_req) begin
                per_gnt = 1'b1;
            end
        end
    end

    // Next state and counter controls. A core grant that interrupts a lock the
    // peripheral still wants is a one-cycle break: the lock state is kept with a
    // fresh lock count so the peripheral re-locks right after that core slot.
    always_comb begin
        state_d    = S_IDLE;
        lock_break = core_gnt && (state_q == S_PER_LOCK) && per_req && per_lock;
        if (per_gnt) begin
            state_d = per_lock ? S_PER_LOCK : S_PER;
        end else if (core_gnt) begin
            state_d = lock_break ? S_PER_LOCK : S_CORE;
        end
        starve_inc = per_req && !per_gnt;
        starve_clr = per_gnt || !per_req;
        lock_inc   = per_gnt && per_lock;
        lock_clr   = (state_d != S_PER_LOCK) || lock_break;
    end

    // Memory-side mux: drive the granted requester, otherwise an idle bus.
    always_comb begin
        mem_addr = '0;
        mem_out  = '0;
        mem_wr   = 4'h0;
        if (core_gnt) begin
            mem_addr = core_addr;
            mem_out  = core_wdata;
            mem_wr   = core_be;
        end else if (per_gnt) begin
            mem_addr = per_addr;
            mem_out  = per_wdata;
            mem_wr   = per_be;
        end
    end

    // Return tag for the access granted this cycle (zero byte enables = read).
    always_comb begin
        tag_d.owner   = per_gnt ? ARB_OWN_PER : ARB_OWN_CORE;
        tag_d.is_read = (core_gnt && (core_be == 4'h0)) || (per_gnt && (per_be == 4'h0));
    end

    // State and return-tag registers; reset drops any read in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
        end
    end

    // Read return routing; the non-owner sees zeros. Suppressed during reset.
    always_comb begin
        core_rvalid = !rst && tag_q.is_read && (tag_q.owner == ARB_OWN_CORE);
        per_rvalid  = !rst && tag_q.is_read && (tag_q.owner == ARB_OWN_PER);
        core_rdata  = core_rvalid ? mem_in : '0;
        per_rdata   = per_rvalid ? mem_in : '0;
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a table of single-cycle vectors plus
// hand-written sequences for starvation, locked bursts and reset mid-read.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req;
    logic [15:0] core_addr;
    logic [31:0] core_wdata;
    logic [3:0]  core_be;
    logic        core_gnt;
    logic [31:0] core_rdata;
    logic        core_rvalid;
    logic        per_req;
    logic        per_lock;
    logic [15:0] per_addr;
    logic [31:0] per_wdata;
    logic [3:0]  per_be;
    logic        per_gnt;
    logic [31:0] per_rdata;
    logic        per_rvalid;
    logic [15:0] mem_addr;
    logic [31:0] mem_out;
    logic [3:0]  mem_wr;
    logic [31:0] mem_in = 32'h0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Data memory stand-in: synchronous read returning 0xA5A5 in the upper half
    // and the word address in the lower half.
    always @(posedge clk) mem_in <= 32'hA5A5_0000 | {16'h0000, mem_addr};

    dmem_port_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .core_req    (core_req),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_be     (core_be),
        .core_gnt    (core_gnt),
        .core_rdata  (core_rdata),
        .core_rvalid (core_rvalid),
        .per_req     (per_req),
        .per_lock    (per_lock),
        .per_addr    (per_addr),
        .per_wdata   (per_wdata),
        .per_be      (per_be),
        .per_gnt     (per_gnt),
        .per_rdata   (per_rdata),
        .per_rvalid  (per_rvalid),
        .mem_addr    (mem_addr),
        .mem_out     (mem_out),
        .mem_wr      (mem_wr),
        .mem_in      (mem_in)
    );

    typedef struct {
        logic        c_req;
        logic [15:0] c_addr;
        logic [3:0]  c_be;
        logic [31:0] c_wd;
        logic        p_req;
        logic        p_lock;
        logic [15:0] p_addr;
        logic [3:0]  p_be;
        logic [31:0] p_wd;
        logic        e_cg;
        logic        e_pg;
        logic        e_crv;
        logic        e_prv;
        logic [31:0] e_crd;
        logic [31:0] e_prd;
        logic [3:0]  e_wr;
        logic [15:0] e_addr;
        logic [31:0] e_out;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic c_req, input logic [15:0] c_addr, input logic [3:0] c_be, input logic [31:0] c_wd,
        input logic p_req, input logic p_lock, input logic [15:0] p_addr, input logic [3:0] p_be,
        input logic [31:0] p_wd, input logic e_cg, input logic e_pg, input logic e_crv, input logic e_prv,
        input logic [31:0] e_crd, input logic [31:0] e_prd, input logic [3:0] e_wr,
        input logic [15:0] e_addr, input logic [31:0] e_out);
        vec_t v;
        v.c_req = c_req; v.c_addr = c_addr; v.c_be = c_be; v.c_wd = c_wd;
        v.p_req = p_req; v.p_lock = p_lock; v.p_addr = p_addr; v.p_be = p_be; v.p_wd = p_wd;
        v.e_cg = e_cg; v.e_pg = e_pg; v.e_crv = e_crv; v.e_prv = e_prv;
        v.e_crd = e_crd; v.e_prd = e_prd; v.e_wr = e_wr; v.e_addr = e_addr; v.e_out = e_out;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        core_req = 1'b0; core_addr = 16'h0; core_wdata = 32'h0; core_be = 4'h0;
        per_req = 1'b0; per_lock = 1'b0; per_addr = 16'h0; per_wdata = 32'h0; per_be = 4'h0;
    endtask

    // Leaves the bench at posedge+1 with reset just released.
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " core_gnt"}, 32'(core_gnt), 32'h0);
        check({tag, " per_gnt"}, 32'(per_gnt), 32'h0);
        check({tag, " core_rvalid"}, 32'(core_rvalid), 32'h0);
        check({tag, " per_rvalid"}, 32'(per_rvalid), 32'h0);
        check({tag, " core_rdata"}, core_rdata, 32'h0);
        check({tag, " per_rdata"}, per_rdata, 32'h0);
        check({tag, " mem_wr"}, 32'(mem_wr), 32'h0);
        check({tag, " mem_addr"}, 32'(mem_addr), 32'h0);
        check({tag, " mem_out"}, mem_out, 32'h0);
    endtask

    initial begin
        // Each vector is one cycle; rvalid/rdata expectations refer to the previous row.
        vecs[0]  = mk(0, 16'h0000, 4'h0, 32'h0,        0, 0, 16'h0000, 4'h0, 32'h0,
                      0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 16'h0000, 32'h0);
        vecs[1]  = mk(0, 16'h0000, 4'h0, 32'h0,        1, 0, 16'h0001, 4'h0, 32'h0,
                      0, 1, 0, 0, 32'h0, 32'h0, 4'h0, 16'h0001, 32'h0);
        vecs[2]  = mk(0, 16'h0000, 4'h0, 32'h0,        0, 0, 16'h0000, 4'h0, 32'h0,
                      0, 0, 0, 1, 32'h0, 32'hA5A5_0001, 4'h0, 16'h0000, 32'h0);
        vecs[3]  = mk(1, 16'h2004, 4'hF, 32'hDEADBEEF, 1, 0, 16'h0010, 4'h0, 32'h0,
                      1, 0, 0, 0, 32'h0, 32'h0, 4'hF, 16'h2004, 32'hDEADBEEF);
        vecs[4]  = mk(0, 16'h0000, 4'h0, 32'h0,        1, 0, 16'h0010, 4'h0, 32'h0,
                      0, 1, 0, 0, 32'h0, 32'h0, 4'h0, 16'h0010, 32'h0);
        vecs[5]  = mk(1, 16'h0100, 4'h0, 32'h0,        0, 0, 16'h0000, 4'h0, 32'h0,
                      1, 0, 0, 1, 32'h0, 32'hA5A5_0010, 4'h0, 16'h0100, 32'h0);
        vecs[6]  = mk(0, 16'h0000, 4'h0, 32'h0,        1, 0, 16'h0020, 4'h0, 32'h0,
                      0, 1, 1, 0, 32'hA5A5_0100, 32'h0, 4'h0, 16'h0020, 32'h0);
        vecs[7]  = mk(1, 16'h0030, 4'h0, 32'h0,        0, 0, 16'h0000, 4'h0, 32'h0,
                      1, 0, 0, 1, 32'h0, 32'hA5A5_0020, 4'h0, 16'h0030, 32'h0);
        vecs[8]  = mk(0, 16'h0000, 4'h0, 32'h0,        1, 0, 16'h0040, 4'h0, 32'h0,
                      0, 1, 1, 0, 32'hA5A5_0030, 32'h0, 4'h0, 16'h0040, 32'h0);
        vecs[9]  = mk(0, 16'h0000, 4'h0, 32'h0,        0, 0, 16'h0000, 4'h0, 32'h0,
                      0, 0, 0, 1, 32'h0, 32'hA5A5_0040, 4'h0, 16'h0000, 32'h0);
        vecs[10] = mk(0, 16'h0000, 4'h0, 32'h0,        1, 0, 16'h0055, 4'h3, 32'h12345678,
                      0, 1, 0, 0, 32'h0, 32'h0, 4'h3, 16'h0055, 32'h12345678);
        vecs[11] = mk(0, 16'h0000, 4'h0, 32'h0,        0, 0, 16'h0000, 4'h0, 32'h0,
                      0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 16'h0000, 32'h0);

        // Reset state, with both requesters asserting to prove grants are held off.
        rst = 1'b1;
        idle_inputs();
        core_req = 1'b1; core_addr = 16'h0123; core_wdata = 32'h1111_2222; core_be = 4'hF;
        per_req = 1'b1; per_addr = 16'h0456;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");

        // Table-driven single-cycle vectors.
        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            core_req = vecs[i].c_req; core_addr = vecs[i].c_addr;
            core_be = vecs[i].c_be; core_wdata = vecs[i].c_wd;
            per_req = vecs[i].p_req; per_lock = vecs[i].p_lock; per_addr = vecs[i].p_addr;
            per_be = vecs[i].p_be; per_wdata = vecs[i].p_wd;
            @(negedge clk);
            check($sformatf("v%0d core_gnt", i), 32'(core_gnt), 32'(vecs[i].e_cg));
            check($sformatf("v%0d per_gnt", i), 32'(per_gnt), 32'(vecs[i].e_pg));
            check($sformatf("v%0d core_rvalid", i), 32'(core_rvalid), 32'(vecs[i].e_crv));
            check($sformatf("v%0d per_rvalid", i), 32'(per_rvalid), 32'(vecs[i].e_prv));
            check($sformatf("v%0d core_rdata", i), core_rdata, vecs[i].e_crd);
            check($sformatf("v%0d per_rdata", i), per_rdata, vecs[i].e_prd);
            check($sformatf("v%0d mem_wr", i), 32'(mem_wr), 32'(vecs[i].e_wr));
            check($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
            check($sformatf("v%0d mem_out", i), mem_out, vecs[i].e_out);
            next_cycle();
        end

        // Both requesting continuously: 8 core grants, then one forced peripheral grant.
        do_reset();
        core_req = 1'b1; core_addr = 16'h0100;
        per_req = 1'b1; per_addr = 16'h0200;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            check($sformatf("starve c%0d core_gnt", i), 32'(core_gnt), 32'((i % 9) != 8));
            check($sformatf("starve c%0d per_gnt", i), 32'(per_gnt), 32'((i % 9) == 8));
            check($sformatf("starve c%0d mem_addr", i), 32'(mem_addr),
                  ((i % 9) == 8) ? 32'h0200 : 32'h0100);
            next_cycle();
        end

        // Locked bursts: 8 core (starvation), then 12 locked peripheral, 1 core, repeat.
        do_reset();
        core_req = 1'b1; core_addr = 16'h0100;
        per_req = 1'b1; per_lock = 1'b1; per_addr = 16'h0200;
        for (int i = 0; i < 34; i++) begin
            logic exp_per;
            exp_per = (i >= 8) && (((i - 8) % 13) < 12);
            @(negedge clk);
            check($sformatf("lock c%0d core_gnt", i), 32'(core_gnt), 32'(!exp_per));
            check($sformatf("lock c%0d per_gnt", i), 32'(per_gnt), 32'(exp_per));
            next_cycle();
        end

        // Reset right after a core read grant: the return must never appear.
        do_reset();
        core_req = 1'b1; core_addr = 16'h0077; core_be = 4'h0;
        @(negedge clk);
        check("rstread grant core_gnt", 32'(core_gnt), 32'h1);
        next_cycle();
        rst = 1'b1;
        per_req = 1'b1; per_addr = 16'h0088;
        @(negedge clk);
        check_all_zero("rstread in_rst");
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        check_all_zero("rstread after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
